// File: rtl/sm_mult_seq_if.sv
// Handshake bundle for sm_mult_seq: operand side (in_*) and product side (out_*).
// slave = multiplier side, master = producer/consumer side.
interface sm_mult_seq_if #(
  parameter int MAG_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [MAG_W:0]     a;
  logic [MAG_W:0]     b;
  logic               out_valid;
  logic               out_ready;
  logic [2*MAG_W:0]   prdct;
  logic               busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prdct, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prdct, busy
  );
endinterface

// File: rtl/sm_mult_seq.sv
// Sequential sign-magnitude multiplier retiring BPC multiplier bits per cycle.
// Optional macro SM_MULT_ZERO_SKIP_EN: zero operands bypass RUN and finish one cycle after accept.
module sm_mult_seq #(
  parameter int MAG_W = 8,
  parameter int BPC   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sm_mult_seq_if.slave bus
);
  localparam int PW    = 2 * MAG_W;
  localparam int STEPS = MAG_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [MAG_W-1:0]   r_mb;
  logic [PW-1:0]      r_ma;
  logic [PW-1:0]      r_ma3;
  logic [PW-1:0]      r_acc;
  logic               r_sign;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic               r_busy;
  logic [PW:0]        r_prdct;

  logic               w_in_ready;
  logic               w_accept;
  logic [MAG_W-1:0]   w_mag_a;
  logic [MAG_W-1:0]   w_mag_b;
  logic [1:0]         w_digit;
  logic [PW-1:0]      w_pp;
  logic [PW-1:0]      w_acc_nxt;
  logic               w_zero_op;

  assign w_mag_a    = bus.a[MAG_W-1:0];
  assign w_mag_b    = bus.b[MAG_W-1:0];
  assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

`ifdef SM_MULT_ZERO_SKIP_EN
  assign w_zero_op = (w_mag_a == '0) | (w_mag_b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  // r_ma / r_ma3 are kept pre-shifted to the current bit position, so the
  // partial product is a plain select; high bits shifted out never matter
  // because the exact product fits in PW bits.
  assign w_digit = 2'(r_mb[BPC-1:0]);

  always_comb begin
    w_pp = '0;
    case (w_digit)
      2'd1:    w_pp = r_ma;
      2'd2:    w_pp = r_ma << 1;
      2'd3:    w_pp = r_ma3;
      default: w_pp = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mb        <= '0;
      r_ma        <= '0;
      r_ma3       <= '0;
      r_acc       <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_prdct     <= '0;
    end else if (w_accept) begin
      // Accept is only possible from IDLE or a draining DONE.
      r_mb   <= w_mag_b;
      r_ma   <= PW'(w_mag_a);
      r_ma3  <= (PW'(w_mag_a) << 1) + PW'(w_mag_a);
      r_sign <= bus.a[MAG_W] ^ bus.b[MAG_W];
      r_acc  <= '0;
      r_cnt  <= CNT_W'(STEPS - 1);
      if (w_zero_op) begin
        r_state     <= S_DONE;
        r_prdct     <= '0;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        r_state     <= S_RUN;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_mb  <= r_mb >> BPC;
          r_ma  <= r_ma << BPC;
          r_ma3 <= r_ma3 << BPC;
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_prdct     <= {r_sign & (w_acc_nxt != '0), w_acc_nxt};
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.prdct     = r_prdct;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sm_mult_seq.sv
// Directed and throttled-random checks of sm_mult_seq at MAG_W=8 with BPC=1 (inst 0) and BPC=2 (inst 1).
module tb_sm_mult_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_mult_seq_if #(.MAG_W(8)) bus0 ();
  sm_mult_seq_if #(.MAG_W(8)) bus1 ();

  sm_mult_seq #(.MAG_W(8), .BPC(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sm_mult_seq #(.MAG_W(8), .BPC(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [1:0]  iv   = 2'b00;
  logic [1:0]  ordy = 2'b00;
  logic [8:0]  ta [2];
  logic [8:0]  tb_ [2];
  wire  [1:0]  ov;
  wire  [1:0]  ir;
  wire  [1:0]  bz;
  wire  [16:0] pr [2];

  assign bus0.in_valid = iv[0];   assign bus1.in_valid = iv[1];
  assign bus0.out_ready = ordy[0]; assign bus1.out_ready = ordy[1];
  assign bus0.a = ta[0];          assign bus1.a = ta[1];
  assign bus0.b = tb_[0];         assign bus1.b = tb_[1];
  assign ov[0] = bus0.out_valid;  assign ov[1] = bus1.out_valid;
  assign ir[0] = bus0.in_ready;   assign ir[1] = bus1.in_ready;
  assign bz[0] = bus0.busy;       assign bz[1] = bus1.busy;
  assign pr[0] = bus0.prdct;      assign pr[1] = bus1.prdct;

`ifdef SM_MULT_ZERO_SKIP_EN
  localparam int   ZLAT0 = 0;
  localparam int   ZLAT1 = 0;
  localparam logic ZBUSY = 1'b0;
`else
  localparam int   ZLAT0 = 8;
  localparam int   ZLAT1 = 4;
  localparam logic ZBUSY = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  function automatic logic [16:0] ref_mul(input logic [8:0] a, input logic [8:0] b);
    logic [15:0] m;
    m = 16'(a[7:0]) * 16'(b[7:0]);
    return {(a[8] ^ b[8]) && (m != 16'd0), m};
  endfunction

  function automatic logic [8:0] rnd_op();
    logic [31:0] r;
    logic [7:0]  mag;
    r = $urandom;
    case (r % 8)
      0:       mag = 8'd0;
      1:       mag = 8'd255;
      default: mag = r[15:8];
    endcase
    return {r[20], mag};
  endfunction

  // Issue one operation from IDLE and wait for its result; edges counts
  // rising edges after the accepting one until out_valid is seen (-1 = timeout).
  task automatic do_op(input int sel, input logic [8:0] a, input logic [8:0] b,
                       output int edges, output logic [16:0] p, output logic bsy_seen);
    int j;
    bsy_seen = 1'b0;
    @(negedge clk);
    ta[sel] = a; tb_[sel] = b; iv[sel] = 1'b1; ordy[sel] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[sel] = 1'b0; ta[sel] = 9'h1FF; tb_[sel] = 9'h1FF;
    j = 0;
    while (!ov[sel] && j < 40) begin
      bsy_seen |= bz[sel];
      @(negedge clk);
      j++;
    end
    edges = ov[sel] ? j : -1;
    p = pr[sel];
  endtask

  task automatic drain(input int sel);
    @(negedge clk); ordy[sel] = 1'b1;
    @(negedge clk); ordy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = 2'b00; ordy = 2'b00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++; if (ov[s] !== 1'b0)     begin bad++; $display("FAIL reset_ov[%0d] got=%b want=0", s, ov[s]); end
      total++; if (pr[s] !== 17'h0)    begin bad++; $display("FAIL reset_prdct[%0d] got=%h want=0", s, pr[s]); end
      total++; if (bz[s] !== 1'b0)     begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", s, bz[s]); end
    end
    rst_n = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      total++; if (ir[s] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b want=1", s, ir[s]); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    ta[0] = 9'h003; tb_[0] = 9'h005; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (ov[0] !== 1'b0)  begin bad++; $display("FAIL midrun_ov got=%b want=0", ov[0]); end
    total++; if (pr[0] !== 17'h0) begin bad++; $display("FAIL midrun_prdct got=%h want=0", pr[0]); end
    total++; if (bz[0] !== 1'b0)  begin bad++; $display("FAIL midrun_busy got=%b want=0", bz[0]); end
    total++; if (ir[0] !== 1'b1)  begin bad++; $display("FAIL midrun_in_ready got=%b want=1", ir[0]); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrun_stale cycle=%0d got=%b want=0", k, ov[0]); end
    end
  endtask

  task automatic test_signed();
    int e; logic [16:0] p; logic bs;
    do_op(0, 9'h019, 9'h10A, e, p, bs);
    total++; if (p !== 17'h100FA) begin bad++; $display("FAIL signed_bpc1 got=%h want=100fa", p); end
    total++; if (e !== 8)         begin bad++; $display("FAIL latency_bpc1 got=%0d want=8", e); end
    drain(0);
    do_op(1, 9'h019, 9'h10A, e, p, bs);
    total++; if (p !== 17'h100FA) begin bad++; $display("FAIL signed_bpc2 got=%h want=100fa", p); end
    total++; if (e !== 4)         begin bad++; $display("FAIL latency_bpc2 got=%0d want=4", e); end
    drain(1);
  endtask

  task automatic test_extremes();
    int e; logic [16:0] p; logic bs;
    do_op(0, 9'h1FF, 9'h1FF, e, p, bs);
    total++; if (p !== 17'h0FE01) begin bad++; $display("FAIL max_neg_neg got=%h want=0fe01", p); end
    drain(0);
    do_op(0, 9'h0FF, 9'h101, e, p, bs);
    total++; if (p !== 17'h100FF) begin bad++; $display("FAIL max_pos_m1 got=%h want=100ff", p); end
    drain(0);
    do_op(1, 9'h1FF, 9'h1FF, e, p, bs);
    total++; if (p !== 17'h0FE01) begin bad++; $display("FAIL max_bpc2 got=%h want=0fe01", p); end
    drain(1);
  endtask

  task automatic test_backpressure();
    int e; logic [16:0] p; logic bs;
    do_op(0, 9'h003, 9'h004, e, p, bs);
    total++; if (p !== 17'h0000C) begin bad++; $display("FAIL bp_first got=%h want=0000c", p); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ta[0] = 9'h002; tb_[0] = 9'h002; iv[0] = 1'b1; ordy[0] = 1'b0;
      #1;
      total++; if (ov[0] !== 1'b1)     begin bad++; $display("FAIL bp_hold_ov k=%0d got=%b want=1", k, ov[0]); end
      total++; if (pr[0] !== 17'h0000C) begin bad++; $display("FAIL bp_hold_prdct k=%0d got=%h want=0000c", k, pr[0]); end
      total++; if (ir[0] !== 1'b0)     begin bad++; $display("FAIL bp_hold_in_ready k=%0d got=%b want=0", k, ir[0]); end
    end
    @(negedge clk);
    ta[0] = 9'h007; tb_[0] = 9'h109; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", ir[0]); end
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0; ordy[0] = 1'b0; ta[0] = 9'h1FF; tb_[0] = 9'h1FF;
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_ov_drop got=%b want=0", ov[0]); end
    total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", bz[0]); end
    e = 0;
    while (!ov[0] && e < 40) begin @(negedge clk); e++; end
    total++; if (e !== 8)          begin bad++; $display("FAIL bp_second_latency got=%0d want=8", e); end
    total++; if (pr[0] !== 17'h1003F) begin bad++; $display("FAIL bp_second_prdct got=%h want=1003f", pr[0]); end
    drain(0);
  endtask

  task automatic test_zero();
    int e; logic [16:0] p; logic bs;
    do_op(0, 9'h100, 9'h107, e, p, bs);
    total++; if (p !== 17'h0)  begin bad++; $display("FAIL zero_prdct0 got=%h want=0", p); end
    total++; if (e !== ZLAT0)  begin bad++; $display("FAIL zero_latency0 got=%0d want=%0d", e, ZLAT0); end
    total++; if (bs !== ZBUSY) begin bad++; $display("FAIL zero_busy0 got=%b want=%b", bs, ZBUSY); end
    drain(0);
    do_op(1, 9'h107, 9'h100, e, p, bs);
    total++; if (p !== 17'h0)  begin bad++; $display("FAIL zero_prdct1 got=%h want=0", p); end
    total++; if (e !== ZLAT1)  begin bad++; $display("FAIL zero_latency1 got=%0d want=%0d", e, ZLAT1); end
    drain(1);
  endtask

  task automatic test_random(input int sel, input int n);
    logic [16:0] q[$];
    logic [8:0]  pa, pb;
    logic        pending;
    int          accepted, results, cyc;
    pending = 1'b0; accepted = 0; results = 0; cyc = 0;
    pa = '0; pb = '0;
    while ((accepted < n || q.size() != 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (!pending && accepted < n && ($urandom % 4) != 0) begin
        pa = rnd_op(); pb = rnd_op(); pending = 1'b1;
      end
      ta[sel] = pending ? pa : rnd_op();
      tb_[sel] = pending ? pb : rnd_op();
      iv[sel] = pending;
      ordy[sel] = (($urandom % 3) != 0);
      #1;
      if (ov[sel] && ordy[sel]) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand%0d_extra got=%h want=none", sel, pr[sel]);
        end else begin
          if (pr[sel] !== q[0]) begin bad++; $display("FAIL rand%0d_result idx=%0d got=%h want=%h", sel, results, pr[sel], q[0]); end
          void'(q.pop_front());
        end
        results++;
      end
      if (iv[sel] && ir[sel]) begin
        q.push_back(ref_mul(pa, pb));
        pending = 1'b0;
        accepted++;
      end
    end
    @(negedge clk);
    iv[sel] = 1'b0; ordy[sel] = 1'b0;
    total++; if (results !== n)  begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", sel, results, n); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rand%0d_pending got=%0d want=0", sel, q.size()); end
  endtask

  initial begin
    ta[0] = '0; ta[1] = '0; tb_[0] = '0; tb_[1] = '0;
    test_reset();
    test_reset_mid_run();
    test_signed();
    test_extremes();
    test_backpressure();
    test_zero();
    test_random(0, 600);
    test_random(1, 600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
